// File: rtl/encoder_round_sched.sv
// Round/stage sequencer for the encoder: fires each sub-unit controller in order through its
// start/ready handshake, NROUNDS times, with a per-stage watchdog that reports hung units.
module encoder_round_sched #(
  parameter int NSTAGES = 4,
  parameter int NROUNDS = 24,
  parameter int ROUND_W = 5,
  parameter int TMO_W   = 8,
  localparam int STAGE_W = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NSTAGES-1:0] stage_ready,
  output logic [NSTAGES-1:0] stage_start,
  output logic [ROUND_W-1:0] round,
  output logic [STAGE_W-1:0] stage,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NSTAGES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NROUNDS - 1);
  // Last count before the watchdog reaches all-ones; the ARM->WAIT step may land on all-ones.
  localparam logic [TMO_W-1:0]   TMO_LAST   = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic               sel_ready_s;
  logic               tmo_hit_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      stage_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      stage_q <= stage_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sel_ready_s = 1'b0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (stage_q == STAGE_W'(i)) begin
        sel_ready_s = stage_ready[i];
      end else begin
        sel_ready_s = sel_ready_s;
      end
    end
  end

  assign tmo_hit_s = (tmo_q >= TMO_LAST);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    stage_d = stage_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          round_d = '0;
          stage_d = '0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_ARM;
      end
      // A ready that never drops is not completion: only the watchdog leaves ARM then.
      S_ARM: begin
        if (!sel_ready_s) begin
          state_d = S_WAIT;
          tmo_d   = tmo_q + TMO_W'(1);
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      S_WAIT: begin
        if (sel_ready_s) begin
          state_d = S_NEXT;
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      S_NEXT: begin
        if (stage_q != LAST_STAGE) begin
          stage_d = stage_q + STAGE_W'(1);
          state_d = S_ISSUE;
        end else if (round_q != LAST_ROUND) begin
          stage_d = '0;
          round_d = round_q + ROUND_W'(1);
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    stage_start = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      if ((state_q == S_ISSUE) && (stage_q == STAGE_W'(i))) begin
        stage_start[i] = 1'b1;
      end else begin
        stage_start[i] = 1'b0;
      end
    end
    ready = (state_q == S_IDLE);
    busy  = (state_q == S_ISSUE) || (state_q == S_ARM) ||
            (state_q == S_WAIT)  || (state_q == S_NEXT);
    done  = (state_q == S_NEXT) && (stage_q == LAST_STAGE) && (round_q == LAST_ROUND);
    round = round_q;
    stage = stage_q;
    err   = err_q;
  end

endmodule

// File: tb/tb_encoder_round_sched.sv
// Directed bench for encoder_round_sched: a 4-stage/2-round instance with modelled sub-units,
// and a 1-stage/1-round instance with an ideal unit.
module tb_encoder_round_sched;

  logic clk = 1'b0;
  bit   clk_run = 1'b1;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 if (clk_run) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-stage, 2-round instance
  logic       start_a;
  logic [3:0] sr_a, ss_a;
  logic [4:0] round_a;
  logic [1:0] stage_a;
  logic       ready_a, busy_a, done_a, err_a;

  encoder_round_sched #(.NSTAGES(4), .NROUNDS(2), .ROUND_W(5), .TMO_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stage_ready(sr_a), .stage_start(ss_a),
    .round(round_a), .stage(stage_a), .ready(ready_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  // 1-stage, 1-round instance
  logic       start_b;
  logic [0:0] sr_b, ss_b;
  logic [0:0] round_b;
  logic [0:0] stage_b;
  logic       ready_b, busy_b, done_b, err_b;

  encoder_round_sched #(.NSTAGES(1), .NROUNDS(1), .ROUND_W(1), .TMO_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stage_ready(sr_b), .stage_start(ss_b),
    .round(round_b), .stage(stage_b), .ready(ready_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Sub-unit models: busy for lat cycles after start; optionally hung low or tied high.
  int unsigned ucnt_a [4];
  logic [3:0]  uhung_a;
  logic [3:0]  stuck_low, tied_high;
  int unsigned lat_a = 2;
  int unsigned ucnt_b;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        ucnt_a[i] <= 0;
        uhung_a[i] <= 1'b0;
      end else if (ss_a[i]) begin
        ucnt_a[i] <= lat_a;
        uhung_a[i] <= stuck_low[i];
      end else if (ucnt_a[i] != 0) begin
        ucnt_a[i] <= ucnt_a[i] - 1;
      end
    end
    if (!rst) ucnt_b <= 0;
    else if (ss_b[0]) ucnt_b <= 1;
    else if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
  end

  always_comb begin
    sr_a = 4'b0000;
    for (int i = 0; i < 4; i++) sr_a[i] = tied_high[i] | (!uhung_a[i] && (ucnt_a[i] == 0));
    sr_b = (ucnt_b == 0) ? 1'b1 : 1'b0;
  end

  // Event monitor on the falling edge.
  int plog[$];
  int pcnt [4];
  int onehot_bad = 0;
  int done_cnt_a = 0, done_cyc_a = 0, acc_cyc_a = 0;
  int pcnt_b = 0, done_cnt_b = 0, done_cyc_b = 0, acc_cyc_b = 0, round_b_bad = 0;

  initial for (int i = 0; i < 4; i++) pcnt[i] = 0;

  always @(negedge clk) begin
    if (ss_a != 4'b0000) begin
      if ($countones(ss_a) != 1) onehot_bad <= onehot_bad + 1;
      for (int i = 0; i < 4; i++) begin
        if (ss_a[i]) begin
          pcnt[i] <= pcnt[i] + 1;
          plog.push_back(i);
        end
      end
    end
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc;
    end
    if (ready_a && start_a) acc_cyc_a <= cyc;
    if (ss_b[0]) pcnt_b <= pcnt_b + 1;
    if (done_b) begin
      done_cnt_b <= done_cnt_b + 1;
      done_cyc_b <= cyc;
    end
    if (ready_b && start_b) acc_cyc_b <= cyc;
    if (round_b != 1'b0) round_b_bad <= round_b_bad + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int base, base_done, base_p2, n;
  bit ok;

  initial begin
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    stuck_low = 4'b0000;
    tied_high = 4'b0000;
    step(); step(); step();
    check("rst_ready", ready_a, 1); check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);   check("rst_err", err_a, 0);
    check("rst_round", round_a, 0); check("rst_stage", stage_a, 0);
    check("rst_sstart", ss_a, 0);   check("rst_b_ready", ready_b, 1);
    rst = 1'b1;
    step();

    // Single normal encode: 8 pulses in order, done 40 cycles after acceptance.
    base = plog.size(); base_done = done_cnt_a;
    start_a = 1'b1; step(); start_a = 1'b0;
    check("issue_busy", busy_a, 1); check("issue_sstart", ss_a, 4'b0001);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin step(); if (done_a) begin ok = 1'b1; break; end end
    check("t1_done_seen", ok, 1);
    check("t1_final_round", round_a, 1); check("t1_final_stage", stage_a, 3);
    step();
    check("t1_ready_after", ready_a, 1); check("t1_busy_after", busy_a, 0);
    check("t1_npulses", plog.size() - base, 8);
    for (int k = 0; k < 8; k++) check("t1_order", plog[base + k], k % 4);
    check("t1_done_once", done_cnt_a - base_done, 1);
    check("t1_latency", done_cyc_a - acc_cyc_a, 40);
    check("t1_onehot", onehot_bad, 0);
    step();
    check("t1_hold_round", round_a, 1);

    // Stage 2 hangs with ready low: timeout 15 cycles into ARM+WAIT.
    stuck_low = 4'b0100; base_done = done_cnt_a;
    start_a = 1'b1; step(); start_a = 1'b0;
    check("t2_round_cleared", round_a, 0);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin step(); if (ss_a[2]) begin ok = 1'b1; break; end end
    check("t2_stage2_issued", ok, 1);
    n = 0;
    for (int k = 0; k < 40; k++) begin step(); n++; if (ready_a) break; end
    check("t2_tmo_cycles", n, 16);
    check("t2_err", err_a, 1); check("t2_busy", busy_a, 0);
    step();
    check("t2_no_done", done_cnt_a - base_done, 0);
    stuck_low = 4'b0000;
    start_a = 1'b1; step(); start_a = 1'b0;
    check("t2_err_cleared", err_a, 0);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin step(); if (done_a) begin ok = 1'b1; break; end end
    check("t2_rerun_done", ok, 1); check("t2_rerun_err", err_a, 0);
    step();

    // Stage 1 never drops ready: timeout in ARM, stage 2 never started.
    tied_high = 4'b0010; base_p2 = pcnt[2]; base_done = done_cnt_a;
    start_a = 1'b1; step(); start_a = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin step(); if (ss_a[1]) begin ok = 1'b1; break; end end
    check("t3_stage1_issued", ok, 1);
    n = 0;
    for (int k = 0; k < 40; k++) begin step(); n++; if (ready_a) break; end
    check("t3_tmo_cycles", n, 16);
    check("t3_err", err_a, 1);
    step();
    check("t3_no_stage2", pcnt[2] - base_p2, 0);
    check("t3_no_done", done_cnt_a - base_done, 0);
    tied_high = 4'b0000;

    // Mid-run start ignored; start held across done relaunches at round 0.
    base = plog.size();
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 10; k++) step();
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 5; k++) step();
    start_a = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin step(); if (done_a) begin ok = 1'b1; break; end end
    check("t4_done_seen", ok, 1);
    step();
    check("t4_npulses", plog.size() - base, 8);
    check("t4_idle_gap", ready_a, 1);
    step();
    check("t4_relaunch_busy", busy_a, 1); check("t4_relaunch_round", round_a, 0);
    check("t4_relaunch_stage", stage_a, 0); check("t4_relaunch_sstart", ss_a, 4'b0001);
    start_a = 1'b0;

    // Reset during round 1 / stage 3 WAIT; no effect while clock is held.
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (ss_a[3] && (round_a == 5'd1)) begin ok = 1'b1; break; end
    end
    check("t5_reach_r1s3", ok, 1);
    step(); step();
    @(negedge clk);
    clk_run = 1'b0;
    rst = 1'b0;
    #30;
    check("t5_held_busy", busy_a, 1); check("t5_held_ready", ready_a, 0);
    check("t5_held_round", round_a, 1); check("t5_held_stage", stage_a, 3);
    clk_run = 1'b1;
    @(posedge clk); #2;
    check("t5_ready", ready_a, 1); check("t5_busy", busy_a, 0);
    check("t5_round", round_a, 0); check("t5_stage", stage_a, 0);
    check("t5_sstart", ss_a, 0);
    rst = 1'b1;
    step();

    // Single stage, single round, ideal unit.
    start_b = 1'b1; step(); start_b = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin step(); if (done_b) begin ok = 1'b1; break; end end
    check("t6_done_seen", ok, 1);
    step(); step();
    check("t6_pulses", pcnt_b, 1); check("t6_done_once", done_cnt_b, 1);
    check("t6_latency", done_cyc_b - acc_cyc_b, 4);
    check("t6_round_zero", round_b_bad, 0); check("t6_ready", ready_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
